// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - EXE-stage to multiply/divide unit bundle
// Purpose: groups the issue, MTHI/MTLO, flush and HI/LO result signals.
// Ports (master = EXE stage, slave = mul_div_unit):
//   op_valid, op_type[1:0], src_a, src_b   operation issue
//   hi_we, lo_we, hilo_wdata               MTHI / MTLO writes
//   flush                                  exception cancel
//   busy, done, hi, lo                     status and architectural HI/LO
interface mul_div_unit_if #(
    parameter int DW = 32
);
    logic          op_valid;
    logic [1:0]    op_type;
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;
    logic          hi_we;
    logic          lo_we;
    logic [DW-1:0] hilo_wdata;
    logic          flush;
    logic          busy;
    logic          done;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    modport master (
        output op_valid, op_type, src_a, src_b, hi_we, lo_we, hilo_wdata, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  op_valid, op_type, src_a, src_b, hi_we, lo_we, hilo_wdata, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Purpose: radix-2 shift-add multiply and restoring divide on operand
//   magnitudes, followed by a one-cycle sign-fix state that writes HI/LO.
// Ports: clk, resetn (async active-low), bus (mul_div_unit_if.slave).
// Option: MUL_DIV_FAST_MUL_EN - multiplies use a single-cycle multiplier and
//   skip CALC (IDLE -> FIX); divide timing is unchanged.
module mul_div_unit #(
    parameter int DW = 32
) (
    input  logic         clk,
    input  logic         resetn,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   b_q, b_d;
    logic [2*DW-1:0] acc_q, acc_d;
    logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic            is_div_q, is_div_d;
    logic            res_neg_q, res_neg_d;
    logic            a_neg_q, a_neg_d;
    logic            dz_q, dz_d;

    // Operand preparation (only meaningful while IDLE accepts an op)
    logic          op_signed, op_div, a_neg, b_neg;
    logic [DW-1:0] a_mag, b_mag;

    assign op_signed = ~bus.op_type[0];
    assign op_div    = bus.op_type[1];
    assign a_neg     = op_signed & bus.src_a[DW-1];
    assign b_neg     = op_signed & bus.src_b[DW-1];
    assign a_mag     = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
    assign b_mag     = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;

`ifdef MUL_DIV_FAST_MUL_EN
    logic [2*DW-1:0] fast_prod;
    assign fast_prod = (2*DW)'(a_mag) * (2*DW)'(b_mag);
`endif

    // acc holds {partial product, multiplier} for multiply and
    // {remainder, dividend/quotient} for divide; both start as {0, |a|}.
    logic [DW:0]     mul_sum;
    logic [2*DW-1:0] mul_next;
    logic [DW:0]     rem_sh;
    logic [DW-1:0]   div_diff;
    logic            div_ge;
    logic [2*DW-1:0] div_next;

    assign mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[DW-1:1]};
    assign rem_sh   = acc_q[2*DW-1:DW-1];
    assign div_ge   = rem_sh >= {1'b0, b_q};
    // When div_ge holds the true difference is below b_q, so DW bits suffice
    assign div_diff = rem_sh[DW-1:0] - b_q;
    assign div_next = {(div_ge ? div_diff : rem_sh[DW-1:0]), acc_q[DW-2:0], div_ge};

    // Sign correction. A zero divisor leaves remainder = |a|, so re-applying
    // the dividend sign gives hi = src_a; only the quotient needs forcing.
    // most-negative / -1 yields magnitude 2^(DW-1) with a positive sign,
    // which is already the most-negative bit pattern.
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   quo_fix, rem_fix;

    assign prod_fix = res_neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix  = dz_q ? '1 :
                      (res_neg_q ? (~acc_q[DW-1:0] + 1'b1) : acc_q[DW-1:0]);
    assign rem_fix  = a_neg_q ? (~acc_q[2*DW-1:DW] + 1'b1) : acc_q[2*DW-1:DW];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        b_d       = b_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        a_neg_d   = a_neg_q;
        dz_d      = dz_q;

        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    b_d       = b_mag;
                    acc_d     = {{DW{1'b0}}, a_mag};
                    is_div_d  = op_div;
                    res_neg_d = a_neg ^ b_neg;
                    a_neg_d   = a_neg;
                    dz_d      = (bus.src_b == '0);
                    cnt_d     = '0;
                    state_d   = CALC;
`ifdef MUL_DIV_FAST_MUL_EN
                    if (!op_div) begin
                        acc_d   = fast_prod;
                        state_d = FIX;
                    end
`endif
                end else begin
                    if (bus.hi_we) hi_d = bus.hilo_wdata;
                    if (bus.lo_we) lo_d = bus.hilo_wdata;
                end
            end
            CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*DW-1:DW];
                    lo_d = prod_fix[DW-1:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush beats both a new issue and the FIX-cycle write
        if (bus.flush) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            a_neg_q   <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            a_neg_q   <= a_neg_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == FIX) & ~bus.flush;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;
    localparam int DW = 32;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mul_div_unit_if #(.DW(DW)) bus ();
    mul_div_unit #(.DW(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    // Monitor: measures busy length up to done, then compares HI/LO one cycle later
    int   busy_cnt = 0;
    bit   pend = 0;
    exp_t cur;
    always @(negedge clk) begin
        if (!resetn) begin
            busy_cnt = 0;
            pend     = 0;
        end else begin
            if (pend) begin
                chk("result_hi", 64'(bus.hi), 64'(cur.hi));
                chk("result_lo", 64'(bus.lo), 64'(cur.lo));
                pend = 0;
            end
            if (bus.busy) busy_cnt++;
            else busy_cnt = 0;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    cur = sb.pop_front();
                    chk("busy_cycles", 64'(busy_cnt), 64'(cur.lat));
                    pend = 1;
                end
            end
        end
    end

    function automatic int lat_of(input logic [1:0] op);
`ifdef MUL_DIV_FAST_MUL_EN
        if (!op[1]) return 1;
`endif
        return DW + 1;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input bit push, input bit mt);
        exp_t e;
        e.hi  = ehi;
        e.lo  = elo;
        e.lat = lat_of(op);
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        bus.op_valid   = 1'b1;
        bus.op_type    = op;
        bus.src_a      = a;
        bus.src_b      = b;
        bus.hi_we      = mt;
        bus.lo_we      = mt;
        bus.hilo_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.hi_we    = 1'b0;
        bus.lo_we    = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 64'(bus.busy), 64'(0));
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
        issue(op, a, b, ehi, elo, 1'b1, 1'b0);
        wait_idle();
    endtask

    initial begin
        bus.op_valid   = 1'b0;
        bus.op_type    = 2'b00;
        bus.src_a      = '0;
        bus.src_b      = '0;
        bus.hi_we      = 1'b0;
        bus.lo_we      = 1'b0;
        bus.hilo_wdata = '0;
        bus.flush      = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));
        chk("reset_hi", 64'(bus.hi), 64'(0));
        chk("reset_lo", 64'(bus.lo), 64'(0));
        @(posedge clk);
        #1 resetn = 1'b1;

        // MTHI/MTLO together, then MTHI alone
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.hilo_wdata = 32'h0000_1234;
        @(posedge clk);
        #1 bus.lo_we = 1'b0; bus.hilo_wdata = 32'h0000_AAAA;
        @(posedge clk);
        #1 bus.hi_we = 1'b0;
        chk("mt_hi", 64'(bus.hi), 64'(32'h0000_AAAA));
        chk("mt_lo", 64'(bus.lo), 64'(32'h0000_1234));

        // Directed vectors with hand-computed results
        run(MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run(MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run(DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run(DIVU,  32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003);
        run(DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF);
        run(DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Second issue and MTHI while busy are both ignored
        issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus.op_valid = 1'b1; bus.op_type = MULTU; bus.src_a = 32'd9; bus.src_b = 32'd9;
        bus.hi_we = 1'b1; bus.hilo_wdata = 32'h5555_5555;
        @(posedge clk);
        #1 bus.op_valid = 1'b0; bus.hi_we = 1'b0;
        wait_idle();

        // Flush mid-divide: no done, HI/LO keep 2/14
        issue(DIV, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'(0));
        chk("flush_hi", 64'(bus.hi), 64'(32'd2));
        chk("flush_lo", 64'(bus.lo), 64'(32'd14));
        repeat (40) @(posedge clk);

        // Issue in the same cycle as MTHI/MTLO: the operation wins
        issue(MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, 1'b1);
        wait_idle();

        // Reset mid-multiply discards it; a new issue works right after release
        issue(MULT, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_hi", 64'(bus.hi), 64'(0));
        chk("rst_lo", 64'(bus.lo), 64'(0));
        @(posedge clk);
        #1 resetn = 1'b1;
        run(DIVU, 32'd7, 32'd2, 32'd1, 32'd3);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
